// File: rtl/sca_blk_alloc_pkg.sv
// rtl/sca_blk_alloc_pkg.sv - shared types, sizes and helpers for the SCA block allocator
package sca_blk_alloc_pkg;

    localparam int NBLK = 16;
    localparam int AW   = 4;

    typedef logic [NBLK-1:0] bmp_t;

    // FSM state constants: RESET -> INIT -> RUN
    typedef logic [1:0] state_t;
    localparam state_t ST_RESET = 2'd0;
    localparam state_t ST_INIT  = 2'd1;
    localparam state_t ST_RUN   = 2'd2;

    // Number of free blocks in a bitmap; one extra bit so a full pool (16) fits.
    function automatic logic [AW:0] popcnt(input bmp_t b);
        logic [AW:0] n;
        n = '0;
        for (int i = 0; i < NBLK; i++) begin
            n = n + {{AW{1'b0}}, b[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/sca_blk_alloc_if.sv
// rtl/sca_blk_alloc_if.sv - request/release/status bundle between SCA write controller, readout sequencer and allocator
//   master : drives ALLOC_REQ, REL_REQ, REL_ADR, FLUSH, MASK; observes grant and status
//   slave  : the allocator; drives READY, ALLOC_ACK, ALLOC_ADR, OVWR, ALLOC_DROP, REL_ERR, NFREE, SCAFULL
interface sca_blk_alloc_if;
    import sca_blk_alloc_pkg::*;

    logic          ALLOC_REQ;
    logic          REL_REQ;
    logic [AW-1:0] REL_ADR;
    logic          FLUSH;
    bmp_t          MASK;

    logic          READY;
    logic          ALLOC_ACK;
    logic [AW-1:0] ALLOC_ADR;
    logic          OVWR;
    logic          ALLOC_DROP;
    logic          REL_ERR;
    logic [AW:0]   NFREE;
    logic          SCAFULL;

    modport master (
        output ALLOC_REQ, REL_REQ, REL_ADR, FLUSH, MASK,
        input  READY, ALLOC_ACK, ALLOC_ADR, OVWR, ALLOC_DROP, REL_ERR, NFREE, SCAFULL
    );

    modport slave (
        input  ALLOC_REQ, REL_REQ, REL_ADR, FLUSH, MASK,
        output READY, ALLOC_ACK, ALLOC_ADR, OVWR, ALLOC_DROP, REL_ERR, NFREE, SCAFULL
    );

endinterface

// File: rtl/sca_blk_alloc_rr_prio_enc.sv
// rtl/sca_blk_alloc_rr_prio_enc.sv - combinational round-robin priority encoder over the free bitmap
//   req   : request (free) vector
//   ptr   : index where the search starts; search wraps modulo NBLK
//   found : at least one request bit set
//   idx   : first set index at or after ptr
module rr_prio_enc
    import sca_blk_alloc_pkg::*;
(
    input  bmp_t          req,
    input  logic [AW-1:0] ptr,
    output logic          found,
    output logic [AW-1:0] idx
);

    logic [2*NBLK-1:0] dbl;
    bmp_t              rot;
    logic [AW-1:0]     off;

    // Rotate so the start pointer lands on bit 0; the lowest set bit of the
    // rotated vector is then the distance from ptr to the winner.
    assign dbl = {req, req} >> ptr;
    assign rot = dbl[NBLK-1:0];

    always_comb begin
        found = |req;
        off   = '0;
        for (int i = NBLK - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = i[AW-1:0];
            end
        end
        idx = ptr + off;
    end

endmodule

// File: rtl/sca_blk_alloc_tmr_reg.sv
// rtl/sca_blk_alloc_tmr_reg.sv - register with optional triplication and bitwise majority vote
//   CLK, RST_B : clock, asynchronous active-low reset (loads RST_VAL)
//   d          : next value, loaded every cycle
//   q          : stored (voted when TMR=1) value
module sca_blk_alloc_tmr_reg #(
    parameter int           W       = 1,
    parameter logic [W-1:0] RST_VAL = '0,
    parameter bit           TMR     = 1'b0
) (
    input  logic         CLK,
    input  logic         RST_B,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    generate
        if (TMR) begin : g_tmr
            logic [W-1:0] r0, r1, r2;
            always_ff @(posedge CLK or negedge RST_B) begin
                if (!RST_B) begin
                    r0 <= RST_VAL;
                    r1 <= RST_VAL;
                    r2 <= RST_VAL;
                end else begin
                    r0 <= d;
                    r1 <= d;
                    r2 <= d;
                end
            end
            // Any single upset copy is outvoted by the other two.
            assign q = (r0 & r1) | (r0 & r2) | (r1 & r2);
        end else begin : g_simplex
            logic [W-1:0] r0;
            always_ff @(posedge CLK or negedge RST_B) begin
                if (!RST_B) begin
                    r0 <= RST_VAL;
                end else begin
                    r0 <= d;
                end
            end
            assign q = r0;
        end
    endgenerate

endmodule

// File: rtl/sca_blk_alloc.sv
// rtl/sca_blk_alloc.sv - SCA storage block allocator and release arbiter (16-block free bitmap)
//   CLK, RST_B : 40 MHz clock, asynchronous active-low reset
//   bus        : slave side of sca_blk_alloc_if (alloc/release/flush in; grant and pool status out)
//   TMR        : 1 triplicates bitmap, pointer and FSM state with majority voting
module sca_blk_alloc
    import sca_blk_alloc_pkg::*;
#(
    parameter bit TMR = 1'b0
) (
    input  logic           CLK,
    input  logic           RST_B,
    sca_blk_alloc_if.slave bus
);

    state_t        state_q, state_d;
    bmp_t          bmp_q, bmp_d;
    bmp_t          mask_q, mask_d;
    bmp_t          set_v, clr_v;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [AW-1:0] adr_q, adr_d;
    logic [AW-1:0] enc_idx;
    logic          enc_found;
    logic          ack_q, ack_d;
    logic          ovwr_q, ovwr_d;
    logic          drop_q, drop_d;
    logic          relerr_q, relerr_d;
    logic [AW:0]   nfree_q, nfree_d;
    logic          full_q, full_d;

    rr_prio_enc u_enc (
        .req   (bmp_q),
        .ptr   (ptr_q),
        .found (enc_found),
        .idx   (enc_idx)
    );

    always_comb begin
        state_d  = state_q;
        bmp_d    = bmp_q;
        mask_d   = mask_q;
        ptr_d    = ptr_q;
        adr_d    = adr_q;
        ack_d    = 1'b0;
        ovwr_d   = 1'b0;
        drop_d   = 1'b0;
        relerr_d = 1'b0;
        set_v    = '0;
        clr_v    = '0;
        case (state_q)
            ST_RESET: begin
                state_d = ST_INIT;
                drop_d  = bus.ALLOC_REQ;
            end
            ST_INIT: begin
                state_d = ST_RUN;
                bmp_d   = ~bus.MASK;
                mask_d  = bus.MASK;
                ptr_d   = '0;
                drop_d  = bus.ALLOC_REQ;
            end
            ST_RUN: begin
                if (bus.FLUSH) begin
                    // Flush wins over everything; a same-cycle release is
                    // swallowed silently since the block is freed anyway.
                    bmp_d  = ~bus.MASK;
                    mask_d = bus.MASK;
                    ptr_d  = '0;
                    drop_d = bus.ALLOC_REQ;
                end else begin
                    if (bus.REL_REQ) begin
                        if (bmp_q[bus.REL_ADR] || mask_q[bus.REL_ADR]) begin
                            relerr_d = 1'b1;
                        end else begin
                            set_v[bus.REL_ADR] = 1'b1;
                        end
                    end
                    // The encoder sees the pre-release bitmap, so a block
                    // released this cycle cannot be granted this cycle.
                    if (bus.ALLOC_REQ) begin
                        ack_d = 1'b1;
                        if (enc_found) begin
                            clr_v[enc_idx] = 1'b1;
                            adr_d          = enc_idx;
                            ptr_d          = enc_idx + {{(AW-1){1'b0}}, 1'b1};
                        end else begin
                            // Pool empty: reuse the last granted block.
                            ovwr_d = 1'b1;
                        end
                    end
                    bmp_d = (bmp_q & ~clr_v) | set_v;
                end
            end
            default: state_d = ST_RESET;
        endcase
        nfree_d = popcnt(bmp_d);
        full_d  = (nfree_d == '0);
    end

    sca_blk_alloc_tmr_reg #(.W($bits(state_t)), .RST_VAL(ST_RESET), .TMR(TMR)) u_state_reg (
        .CLK (CLK), .RST_B (RST_B), .d (state_d), .q (state_q)
    );

    sca_blk_alloc_tmr_reg #(.W(NBLK), .RST_VAL('0), .TMR(TMR)) u_bmp_reg (
        .CLK (CLK), .RST_B (RST_B), .d (bmp_d), .q (bmp_q)
    );

    sca_blk_alloc_tmr_reg #(.W(AW), .RST_VAL('0), .TMR(TMR)) u_ptr_reg (
        .CLK (CLK), .RST_B (RST_B), .d (ptr_d), .q (ptr_q)
    );

    // adr_q doubles as the "last granted" block used on overwrite.
    always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
            mask_q   <= '0;
            adr_q    <= '0;
            ack_q    <= 1'b0;
            ovwr_q   <= 1'b0;
            drop_q   <= 1'b0;
            relerr_q <= 1'b0;
            nfree_q  <= '0;
            full_q   <= 1'b1;
        end else begin
            mask_q   <= mask_d;
            adr_q    <= adr_d;
            ack_q    <= ack_d;
            ovwr_q   <= ovwr_d;
            drop_q   <= drop_d;
            relerr_q <= relerr_d;
            nfree_q  <= nfree_d;
            full_q   <= full_d;
        end
    end

    assign bus.READY      = (state_q == ST_RUN);
    assign bus.ALLOC_ACK  = ack_q;
    assign bus.ALLOC_ADR  = adr_q;
    assign bus.OVWR       = ovwr_q;
    assign bus.ALLOC_DROP = drop_q;
    assign bus.REL_ERR    = relerr_q;
    assign bus.NFREE      = nfree_q;
    assign bus.SCAFULL    = full_q;

endmodule

// File: tb/tb_sca_blk_alloc.sv
// tb/tb_sca_blk_alloc.sv - self-checking bench for sca_blk_alloc
module tb_sca_blk_alloc;
    import sca_blk_alloc_pkg::*;

    logic CLK   = 1'b0;
    logic RST_B = 1'b1;

    sca_blk_alloc_if bus ();

    sca_blk_alloc dut (
        .CLK   (CLK),
        .RST_B (RST_B),
        .bus   (bus.slave)
    );

    always #5 CLK = ~CLK;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act != exp) $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        else n_pass++;
    endtask

    // Pool model: free list as a bit array, search by walking indices.
    bit m_free [16];
    bit m_mask [16];
    int m_ptr   = 0;
    int m_last  = 0;
    int m_since = 0;
    int m_fidx;
    int m_ra;
    bit m_dorel;
    int e_ready  = 0;
    int e_ack    = 0;
    int e_ovwr   = 0;
    int e_drop   = 0;
    int e_relerr = 0;
    int e_adr    = 0;
    int e_nfree  = 0;

    always @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
            for (int i = 0; i < 16; i++) begin
                m_free[i] = 1'b0;
                m_mask[i] = 1'b0;
            end
            m_ptr = 0; m_last = 0; m_since = 0;
            e_ready = 0; e_ack = 0; e_ovwr = 0; e_drop = 0; e_relerr = 0;
            e_adr = 0; e_nfree = 0;
        end else begin
            e_ack = 0; e_ovwr = 0; e_drop = 0; e_relerr = 0;
            if (m_since < 2 || bus.FLUSH) begin
                e_drop = int'(bus.ALLOC_REQ);
                if (m_since >= 1) begin
                    for (int i = 0; i < 16; i++) begin
                        m_free[i] = !bus.MASK[i];
                        m_mask[i] = bus.MASK[i];
                    end
                    m_ptr = 0;
                end
                if (m_since < 2) m_since++;
            end else begin
                m_ra    = int'(bus.REL_ADR);
                m_dorel = 1'b0;
                if (bus.REL_REQ) begin
                    if (m_free[m_ra] || m_mask[m_ra]) e_relerr = 1;
                    else m_dorel = 1'b1;
                end
                if (bus.ALLOC_REQ) begin
                    e_ack  = 1;
                    m_fidx = -1;
                    for (int k = 0; k < 16; k++) begin
                        if (m_fidx < 0 && m_free[(m_ptr + k) % 16]) m_fidx = (m_ptr + k) % 16;
                    end
                    if (m_fidx >= 0) begin
                        m_free[m_fidx] = 1'b0;
                        m_last = m_fidx;
                        m_ptr  = (m_fidx + 1) % 16;
                    end else begin
                        e_ovwr = 1;
                    end
                end
                if (m_dorel) m_free[m_ra] = 1'b1;
            end
            e_ready = (m_since >= 2) ? 1 : 0;
            e_adr   = m_last;
            e_nfree = 0;
            for (int i = 0; i < 16; i++) e_nfree += int'(m_free[i]);
        end
    end

    always @(negedge CLK) begin
        chk("READY",      int'(bus.READY),      e_ready);
        chk("ALLOC_ACK",  int'(bus.ALLOC_ACK),  e_ack);
        chk("ALLOC_ADR",  int'(bus.ALLOC_ADR),  e_adr);
        chk("OVWR",       int'(bus.OVWR),       e_ovwr);
        chk("ALLOC_DROP", int'(bus.ALLOC_DROP), e_drop);
        chk("REL_ERR",    int'(bus.REL_ERR),    e_relerr);
        chk("NFREE",      int'(bus.NFREE),      e_nfree);
        chk("SCAFULL",    int'(bus.SCAFULL),    (e_nfree == 0) ? 1 : 0);
    end

    // Called at a negedge; drives one cycle of inputs and returns at the next negedge.
    task automatic step(input logic a, input logic r, input logic [3:0] ra, input logic f);
        bus.ALLOC_REQ = a;
        bus.REL_REQ   = r;
        bus.REL_ADR   = ra;
        bus.FLUSH     = f;
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic do_reset(input logic [15:0] m);
        #1 RST_B = 1'b0;
        bus.ALLOC_REQ = 1'b0;
        bus.REL_REQ   = 1'b0;
        bus.REL_ADR   = '0;
        bus.FLUSH     = 1'b0;
        bus.MASK      = m;
        repeat (2) @(negedge CLK);
        chk("rst_ready", int'(bus.READY), 0);
        chk("rst_nfree", int'(bus.NFREE), 0);
        chk("rst_full",  int'(bus.SCAFULL), 1);
        chk("rst_adr",   int'(bus.ALLOC_ADR), 0);
        RST_B = 1'b1;
    endtask

    initial begin
        bus.ALLOC_REQ = 1'b0;
        bus.REL_REQ   = 1'b0;
        bus.REL_ADR   = '0;
        bus.FLUSH     = 1'b0;
        bus.MASK      = '0;

        // Reset release, full sequential drain
        do_reset(16'h0000);
        step(0, 0, 0, 0);
        chk("ready_edge1", int'(bus.READY), 0);
        step(0, 0, 0, 0);
        chk("ready_edge2", int'(bus.READY), 1);
        chk("nfree_init",  int'(bus.NFREE), 16);
        for (int k = 0; k < 16; k++) begin
            step(1, 0, 0, 0);
            chk("drain_adr",   int'(bus.ALLOC_ADR), k);
            chk("drain_nfree", int'(bus.NFREE), 15 - k);
        end
        chk("drain_full", int'(bus.SCAFULL), 1);

        // Empty pool overwrite, then release and reuse
        step(1, 0, 0, 0);
        chk("ovwr_ack", int'(bus.ALLOC_ACK), 1);
        chk("ovwr_adr", int'(bus.ALLOC_ADR), 15);
        chk("ovwr",     int'(bus.OVWR), 1);
        step(0, 1, 4'd3, 0);
        chk("rel3_nfree", int'(bus.NFREE), 1);
        step(1, 0, 0, 0);
        chk("realloc3", int'(bus.ALLOC_ADR), 3);
        chk("realloc3_ovwr", int'(bus.OVWR), 0);

        // Empty pool with simultaneous release: still an overwrite
        step(1, 1, 4'd7, 0);
        chk("simul_ovwr", int'(bus.OVWR), 1);
        chk("simul_adr",  int'(bus.ALLOC_ADR), 3);
        chk("simul_nfree", int'(bus.NFREE), 1);
        step(1, 0, 0, 0);
        chk("alloc7", int'(bus.ALLOC_ADR), 7);

        // Wrap: pointer at 8, free {1,14} -> 14 then 1
        step(0, 1, 4'd1, 0);
        step(0, 1, 4'd14, 0);
        chk("wrap_nfree", int'(bus.NFREE), 2);
        step(1, 0, 0, 0);
        chk("wrap_a", int'(bus.ALLOC_ADR), 14);
        step(1, 0, 0, 0);
        chk("wrap_b", int'(bus.ALLOC_ADR), 1);

        // Only block 9 free; alloc + release 2 in one cycle
        step(0, 1, 4'd9, 0);
        step(1, 1, 4'd2, 0);
        chk("only9_adr",   int'(bus.ALLOC_ADR), 9);
        chk("only9_nfree", int'(bus.NFREE), 1);
        step(1, 0, 0, 0);
        chk("then2", int'(bus.ALLOC_ADR), 2);

        // Double release
        step(0, 1, 4'd2, 0);
        chk("rel_ok_err", int'(bus.REL_ERR), 0);
        step(0, 1, 4'd2, 0);
        chk("rel_dup_err",   int'(bus.REL_ERR), 1);
        chk("rel_dup_nfree", int'(bus.NFREE), 1);

        // Flush with alloc and an otherwise-erroneous release
        step(1, 1, 4'd2, 1);
        chk("flush_drop",   int'(bus.ALLOC_DROP), 1);
        chk("flush_ack",    int'(bus.ALLOC_ACK), 0);
        chk("flush_relerr", int'(bus.REL_ERR), 0);
        chk("flush_nfree",  int'(bus.NFREE), 16);
        step(1, 0, 0, 0);
        chk("post_flush_adr", int'(bus.ALLOC_ADR), 0);

        // Masked blocks 4..7
        do_reset(16'h00F0);
        step(1, 0, 0, 0);
        chk("early_drop1", int'(bus.ALLOC_DROP), 1);
        step(1, 0, 0, 0);
        chk("early_drop2", int'(bus.ALLOC_DROP), 1);
        chk("mask_nfree",  int'(bus.NFREE), 12);
        for (int k = 0; k < 5; k++) begin
            logic [3:0] exp_adr [5];
            exp_adr = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd8};
            step(1, 0, 0, 0);
            chk("mask_adr", int'(bus.ALLOC_ADR), int'(exp_adr[k]));
        end
        chk("mask_nfree2", int'(bus.NFREE), 7);
        step(0, 1, 4'd5, 0);
        chk("mask_relerr", int'(bus.REL_ERR), 1);
        chk("mask_rel_nfree", int'(bus.NFREE), 7);

        // Reset asserted mid-burst
        bus.ALLOC_REQ = 1'b1;
        @(posedge CLK);
        #2 RST_B = 1'b0;
        #1;
        chk("mid_rst_ack",   int'(bus.ALLOC_ACK), 0);
        chk("mid_rst_ready", int'(bus.READY), 0);
        chk("mid_rst_nfree", int'(bus.NFREE), 0);
        chk("mid_rst_full",  int'(bus.SCAFULL), 1);
        chk("mid_rst_adr",   int'(bus.ALLOC_ADR), 0);

        // Everything masked
        do_reset(16'hFFFF);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("allmask_nfree", int'(bus.NFREE), 0);
        step(1, 0, 0, 0);
        chk("allmask_ovwr", int'(bus.OVWR), 1);
        chk("allmask_adr",  int'(bus.ALLOC_ADR), 0);
        step(0, 0, 0, 1);
        chk("allmask_flush_nfree", int'(bus.NFREE), 0);
        step(0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sca_blk_alloc.md
# sca_blk_alloc

SCA block allocator and release arbiter for the CFEB trigger/readout path. It keeps the pool of 16 SCA storage blocks as a free-bitmap. Each LCT-driven write request receives the next free block in round-robin order, and blocks are returned to the pool when readout completes. It sits between the SCA write controller (requester) and the readout sequencer (releaser), and supplies the free-block count and SCA-full flag to the status and error-word path.

## Interface
- TMR, 0: when 1, the bitmap, pointer and FSM state registers are triplicated with majority voting; behaviour is otherwise identical.
- CLK  in  1  system clock (40 MHz domain); all logic is on its rising edge.
- RST_B  in  1  asynchronous, active-low reset.
- ALLOC_REQ  in  1  one-cycle request for a block.
- REL_REQ  in  1  one-cycle release of block REL_ADR.
- REL_ADR  in  4  block being released.
- FLUSH  in  1  returns all unmasked blocks to free.
- MASK  in  16  bit i=1 excludes block i from the pool; sampled only in INIT and on FLUSH.
- READY  out  1  allocator in RUN state.
- ALLOC_ACK  out  1  one-cycle grant.
- ALLOC_ADR  out  4  granted block, valid with ALLOC_ACK, held between grants.
- OVWR  out  1  pulse: grant made with no free block (reused block).
- ALLOC_DROP  out  1  pulse: request ignored (not READY or FLUSH cycle).
- REL_ERR  out  1  pulse: release of an already-free or masked block.
- NFREE  out  5  registered free-block count, 0..16.
- SCAFULL  out  1  NFREE==0.

## Operation
- FSM states: RESET → INIT → RUN.
  - While RST_B=0: bitmap is all-used, pointer=0, last=0, all pulses 0, ALLOC_ADR=0, NFREE=0, SCAFULL=1, READY=0.
  - INIT lasts exactly one cycle after RST_B rises: bitmap ← ~MASK, then go to RUN.
- Allocation in RUN:
  - On ALLOC_REQ, search the free bitmap starting at pointer, wrapping modulo 16, and pick the first free index.
  - Registered result: ALLOC_ACK=1, ALLOC_ADR=index, bit cleared, pointer ← index+1 (mod 16), last ← index.
- Pool empty:
  - ALLOC_REQ with no free block still returns ALLOC_ACK=1, with ALLOC_ADR=last and OVWR=1.
  - Bitmap and pointer are unchanged. This matches the "SCA full: overwrite same block" error policy.
- Release:
  - REL_REQ sets bit REL_ADR.
  - If that bit is already free or the block is masked, nothing changes and REL_ERR=1.
- Simultaneous alloc and release in the same cycle:
  - Both are applied.
  - The released block is not eligible for that allocation; it becomes eligible from the next cycle.
  - If the pool was empty, OVWR is still asserted.
- FLUSH (highest priority):
  - Bitmap ← ~MASK, pointer ← 0. last is unchanged.
  - A same-cycle ALLOC_REQ is dropped (ALLOC_DROP=1). A same-cycle REL_REQ is ignored without REL_ERR.
- ALLOC_REQ while READY=0 gives ALLOC_DROP=1 and no grant.
- NFREE is the popcount of the bitmap after the update; SCAFULL follows NFREE.
- Width rules:
  - Pointer is 4 bits and wraps 15→0 naturally.
  - NFREE is 5 bits, so that 16 is representable.
- With all 16 blocks masked: NFREE=0 permanently and every grant is an OVWR reusing last (0 after reset).

## Timing
- Request sampled at edge n; ALLOC_ACK, ALLOC_ADR and OVWR are registered at edge n+1 (1-cycle latency). Back-to-back requests on every cycle are supported.
- Release at edge n: the bit is visible to allocation and NFREE at n+1.
- All outputs are registered. No combinational path from inputs to outputs.
- READY rises at the second rising edge after RST_B deassertion.
- RST_B assertion mid-operation clears state asynchronously within the same cycle; any in-flight ACK is lost.

## Structure
- Package sca_blk_alloc_pkg contains:
  - NBLK=16, AW=4;
  - the FSM state typedef (RESET, INIT, RUN);
  - the bitmap typedef logic [NBLK-1:0].
- Sub-module rr_prio_enc: 16-bit round-robin priority encoder.
  - Inputs: request vector and start pointer.
  - Outputs: found flag and 4-bit index.
  - Purely combinational; instantiated once.
- The TMR voters reuse the existing voter cells.

## Test plan
- Reset release with MASK=0 → READY=1 at the second edge, NFREE=16; 16 back-to-back ALLOC_REQ → ADR 0,1,…,15, with NFREE decreasing to 0 and SCAFULL=1.
- Pool empty (last=15), ALLOC_REQ → ACK, ADR=15, OVWR=1, NFREE stays 0; then REL_ADR=3 → NFREE=1, and the next ALLOC gives ADR=3.
- MASK=16'h00F0, reset → NFREE=12; allocations skip 4–7; REL_ADR=5 → REL_ERR=1, NFREE unchanged.
- Pool has only block 9 free; same cycle ALLOC_REQ plus REL_ADR=2 → grant ADR=9, and NFREE is unchanged across the cycle.
- Wrap check: pointer=14, free set {1,14} → grants 14 then 1 (pointer wraps 15→0).
- FLUSH with ALLOC_REQ in the same cycle → ALLOC_DROP=1, no ACK, NFREE=16−popcount(MASK); RST_B pulsed mid-burst → outputs at reset values immediately.
